// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - flag-tagging result FIFO with OR accumulator
module alu_result_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_zero,
  output logic                     out_ones,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     acc_clr,
  output logic [WIDTH-1:0]         acc
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + 2;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [EW-1:0]    head_q, head_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [EW-1:0]    entry_in;
  logic             empty, full, push, pop;

  always_comb begin
    empty    = (wr_q == rd_q);
    full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    push     = in_valid && !full;
    pop      = !empty && out_ready;
    entry_in = {in_result, ~|in_result, &in_result};
    wr_d     = wr_q + {{AW{1'b0}}, push};
    rd_d     = rd_q + {{AW{1'b0}}, pop};

    // Head is registered so it holds its last value once the queue drains;
    // a push landing in the slot that becomes head must bypass storage.
    head_d = head_q;
    if (wr_d != rd_d) begin
      if (push && (wr_q == rd_d)) head_d = entry_in;
      else                        head_d = mem_q[rd_d[AW-1:0]];
    end

    acc_d = acc_q;
    if (acc_clr)   acc_d = push ? in_result : '0;
    else if (push) acc_d = acc_q | in_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
      acc_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
      acc_q  <= acc_d;
      if (push) mem_q[wr_q[AW-1:0]] <= entry_in;
    end
  end

  assign in_ready   = !full;
  assign out_valid  = !empty;
  assign out_result = head_q[EW-1:2];
  assign out_zero   = head_q[1];
  assign out_ones   = head_q[0];
  assign count      = wr_q - rd_q;
  assign acc        = acc_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - directed self-checking bench for alu_result_buffer
module tb_alu_result_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_result;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_zero;
  logic       out_ones;
  logic [2:0] count;
  logic       acc_clr;
  logic [3:0] acc;

  int tests = 0;
  int fails = 0;

  alu_result_buffer #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_ones(out_ones),
    .count(count), .acc_clr(acc_clr), .acc(acc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_result = 0; out_ready = 0; acc_clr = 0;
    repeat (2) step();
    rst = 1'b0;
    in_valid = 1; in_result = 4'd13;
    step(); step();
    in_valid = 0;
    #3;
    rst = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL async_rst in_ready got %0b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL async_rst out_valid got %0b exp 0", out_valid); end
    tests++; if (out_result !== 4'd0) begin fails++; $display("FAIL async_rst out_result got %0d exp 0", out_result); end
    tests++; if (out_zero !== 1'b0 || out_ones !== 1'b0) begin fails++; $display("FAIL async_rst flags got %0b%0b exp 00", out_zero, out_ones); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL async_rst count got %0d exp 0", count); end
    tests++; if (acc !== 4'd0) begin fails++; $display("FAIL async_rst acc got %0d exp 0", acc); end
    step();
    rst = 1'b0;
    in_valid = 1; in_result = 4'b0110;
    step();
    in_valid = 0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL push6 out_valid got %0b exp 1", out_valid); end
    tests++; if (out_result !== 4'd6) begin fails++; $display("FAIL push6 out_result got %0d exp 6", out_result); end
    tests++; if (out_zero !== 1'b0 || out_ones !== 1'b0) begin fails++; $display("FAIL push6 flags got %0b%0b exp 00", out_zero, out_ones); end
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL push6 count got %0d exp 1", count); end
    tests++; if (acc !== 4'd6) begin fails++; $display("FAIL push6 acc got %0d exp 6", acc); end
    out_ready = 1;
    step();
    out_ready = 0;
    tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL push6_drain count got %0d exp 0", count); end
  endtask

  task automatic test_flags();
    in_valid = 1;
    in_result = 4'd0;  step();
    in_result = 4'd15; step();
    in_result = 4'd9;  step();
    in_valid = 0;
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL flags count got %0d exp 3", count); end
    tests++; if (acc !== 4'd15) begin fails++; $display("FAIL flags acc got %0d exp 15", acc); end
    tests++; if (out_result !== 4'd0 || out_zero !== 1'b1 || out_ones !== 1'b0) begin fails++; $display("FAIL flags head0 got %0d z%0b o%0b exp 0 z1 o0", out_result, out_zero, out_ones); end
    out_ready = 1;
    step();
    tests++; if (out_result !== 4'd15 || out_zero !== 1'b0 || out_ones !== 1'b1) begin fails++; $display("FAIL flags head15 got %0d z%0b o%0b exp 15 z0 o1", out_result, out_zero, out_ones); end
    step();
    tests++; if (out_result !== 4'd9 || out_zero !== 1'b0 || out_ones !== 1'b0) begin fails++; $display("FAIL flags head9 got %0d z%0b o%0b exp 9 z0 o0", out_result, out_zero, out_ones); end
    step();
    out_ready = 0;
    tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL flags_drain count got %0d exp 0", count); end
  endtask

  task automatic test_full_wrap();
    in_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      in_result = i[3:0];
      step();
    end
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL full count got %0d exp 4", count); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full in_ready got %0b exp 0", in_ready); end
    in_result = 4'd5;
    step();
    tests++; if (count !== 3'd4 || out_result !== 4'd1) begin fails++; $display("FAIL full_offer count got %0d head %0d exp 4 head 1", count, out_result); end
    out_ready = 1;
    step();
    out_ready = 0;
    tests++; if (in_ready !== 1'b1 || count !== 3'd3) begin fails++; $display("FAIL full_pop in_ready got %0b count %0d exp 1 count 3", in_ready, count); end
    step();
    in_valid = 0;
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_accept5 count got %0d exp 4", count); end
    out_ready = 1;
    for (int i = 2; i <= 5; i++) begin
      tests++; if (out_valid !== 1'b1 || out_result !== i[3:0]) begin fails++; $display("FAIL wrap_drain got %0d valid %0b exp %0d", out_result, out_valid, i); end
      step();
    end
    out_ready = 0;
    tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL wrap_empty count got %0d exp 0", count); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] q[$];
    q = {};
    in_valid = 1;
    in_result = 4'd10; step(); q.push_back(4'd10);
    in_result = 4'd11; step(); q.push_back(4'd11);
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      in_result = i[3:0];
      step();
      q.push_back(i[3:0]);
      void'(q.pop_front());
      tests++; if (count !== 3'd2 || out_result !== q[0]) begin fails++; $display("FAIL b2b step %0d count %0d head %0d exp count 2 head %0d", i, count, out_result, q[0]); end
    end
    in_valid = 0;
    step();
    tests++; if (count !== 3'd1 || out_result !== 4'd8) begin fails++; $display("FAIL b2b_drain count %0d head %0d exp 1 head 8", count, out_result); end
    step();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL b2b_empty count got %0d exp 0", count); end
    in_valid = 1; in_result = 4'd3;
    step();
    in_valid = 0; out_ready = 0;
    tests++; if (count !== 3'd1 || out_valid !== 1'b1 || out_result !== 4'd3) begin fails++; $display("FAIL empty_simul count %0d head %0d exp 1 head 3", count, out_result); end
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  task automatic test_acc();
    acc_clr = 1; in_valid = 1; in_result = 4'b0011;
    step();
    tests++; if (acc !== 4'd3) begin fails++; $display("FAIL acc_clr_push3 got %0d exp 3", acc); end
    in_valid = 0;
    step();
    tests++; if (acc !== 4'd0) begin fails++; $display("FAIL acc_clr_only got %0d exp 0", acc); end
    in_valid = 1; in_result = 4'd8;
    step();
    tests++; if (acc !== 4'd8) begin fails++; $display("FAIL acc_clr_push8 got %0d exp 8", acc); end
    acc_clr = 0; in_result = 4'd1;
    step();
    in_valid = 0;
    tests++; if (acc !== 4'd9) begin fails++; $display("FAIL acc_or got %0d exp 9", acc); end
    step();
    tests++; if (acc !== 4'd9 || count !== 3'd3) begin fails++; $display("FAIL acc_hold got %0d count %0d exp 9 count 3", acc, count); end
  endtask

  task automatic test_reset_midstream();
    in_valid = 1; in_result = 4'd7;
    #2;
    rst = 1;
    step();
    tests++; if (count !== 3'd0 || out_valid !== 1'b0 || acc !== 4'd0) begin fails++; $display("FAIL rst_mid count %0d valid %0b acc %0d exp 0 0 0", count, out_valid, acc); end
    rst = 0; in_valid = 0;
    step();
    tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_after count %0d valid %0b exp 0 0", count, out_valid); end
    tests++; if (out_result === 4'd7) begin fails++; $display("FAIL rst_mid_ghost out_result got %0d exp not 7", out_result); end
  endtask

  initial begin
    test_reset();
    test_flags();
    test_full_wrap();
    test_back_to_back();
    test_acc();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Registered result stage that sits directly downstream of the 4-bit bitwise logic unit (`bitOR`). It accepts each `WIDTH`-bit result through a valid/ready handshake, tags it with zero and all-ones flags, and queues it in a small FIFO for the consumer. It also keeps a running OR-accumulator of every accepted result.

## Interface
- `WIDTH`, default 4: result width; matches the logic unit output.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  producer has a result on `in_result`.
- `in_ready`  out  1  buffer can accept; equals `!full`.
- `in_result`  in  WIDTH  result from the logic unit.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer takes the head entry.
- `out_result`  out  WIDTH  head entry data.
- `out_zero`  out  1  head entry was all zeros.
- `out_ones`  out  1  head entry was all ones.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `acc_clr`  in  1  synchronous clear of the accumulator.
- `acc`  out  WIDTH  OR of all results accepted since reset or last clear.

## Operation
- Push: fires when `in_valid && in_ready`. It writes `{in_result, zero, ones}` at the write pointer. `zero = (in_result == 0)`; `ones = &in_result`. Flags are computed at write time and stored with the entry.
- Pop: fires when `out_valid && out_ready`. It advances the read pointer.
- Pointers are `$clog2(DEPTH)+1` bits and wrap modulo 2·DEPTH.
  - empty: pointers are fully equal.
  - full: low bits are equal and the MSBs differ.
- `count` is the write pointer minus the read pointer, modulo 2·DEPTH. Its range is 0..DEPTH.
- `out_valid = !empty`. The `out_*` outputs come from the head entry. When empty, `out_result`, `out_zero`, `out_ones` hold their last value; consumers must ignore them.
- Simultaneous push and pop:
  - Not empty and not full: both happen, and `count` is unchanged.
  - Full: `in_ready=0`, so only the pop happens.
  - Empty: `out_valid=0`, so only the push happens.
- Accumulator, per cycle:
  - If `acc_clr`: `acc <= push ? in_result : 0`. A clear and a push in the same cycle keep only the new result.
  - Otherwise, if push: `acc <= acc | in_result`.
  - Otherwise `acc` holds.
- `in_valid` while full is not an error. The producer must hold `in_result` until `in_ready`. Nothing is dropped.
- Reset mid-operation discards all queued entries immediately, including any in-flight push or pop in that cycle.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_result=0`, `out_zero=0`, `out_ones=0`, `count=0`, `acc=0`. Pointers and storage are also 0.
- Latency: a result pushed at edge N is visible on `out_*` with `out_valid=1` after edge N. There is one cycle of latency and no combinational fall-through.
- `in_ready` and `out_valid` depend only on registered state. They have no combinational path from `in_valid` or `out_ready`.
- `count`, `acc`, and the pointers update on the same edge as the push or pop that changes them.
- Throughput: one push and one pop per cycle sustained while 0 < `count` < DEPTH.

## Test plan
- Reset and basic push:
  - Assert `rst` asynchronously mid-cycle: all outputs take their reset values without waiting for an edge.
  - Release reset, push `in_result=4'b0110` (6|4): next cycle `out_valid=1`, `out_result=6`, `out_zero=0`, `out_ones=0`, `count=1`, `acc=6`.
- Flags: push 0, then 15, then 9, with `out_ready=0`.
  - Heads then read 0 with zero=1; 15 with ones=1; 9 with both flags 0, in that order.
  - `acc=15` and `count=3`.
- Full and wrap:
  - Push 1,2,3,4 with `out_ready=0`: `count=4`, `in_ready=0`.
  - Offer 5 with `in_valid=1`: it is not accepted.
  - Pop once: `in_ready=1` the next cycle, and 5 is then accepted.
  - Drain: 2,3,4,5 come out in order, covering pointer wrap.
- Simultaneous push and pop:
  - At `count=2`, hold both handshakes for 8 cycles with values 1..8: `count` stays 2 and output order is preserved.
  - At `count=0`, `in_valid=1` and `out_ready=1` in the same cycle: only the push happens, giving `count=1`.
- Accumulator:
  - With `acc=4'b0011`, pulse `acc_clr` with no push: `acc=0`.
  - Pulse `acc_clr` together with a push of 8: `acc=8`.
  - Push 1 next cycle: `acc=9`.
- Reset mid-stream: with `count=3`, assert `rst` during a push: `count=0`, `out_valid=0`, `acc=0`, and the pushed value never appears.
